mc_ctrl: RTL



---
 rtl/mc_ctrl_if.sv | 44 ++++
 rtl/mc_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if : control-unit <-> datapath signal bundle for the multi-cycle MIPS
// controller.
//   master modport (controller):
//     inputs  OP, Funct (IR fields), Zero (ALU flag), mem_rdy (memory done)
//     outputs mem_req, PCWr, IRWr, RFWr, DMWr, BSel, WDSel, GPRSel, NPCOp,
//             EXTOp, ALUOp, state, illegal, instret
//   slave modport (datapath / memory side): same signals, opposite directions.
// -----------------------------------------------------------------------------
interface mc_ctrl_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) ();
    logic [5:0]         OP;
    logic [5:0]         Funct;
    logic               Zero;
    logic               mem_rdy;
    logic               mem_req;
    logic               PCWr;
    logic               IRWr;
    logic               RFWr;
    logic               DMWr;
    logic               BSel;
    logic [1:0]         WDSel;
    logic [1:0]         GPRSel;
    logic [1:0]         NPCOp;
    logic [1:0]         EXTOp;
    logic [ALUOP_W-1:0] ALUOp;
    logic [2:0]         state;
    logic               illegal;
    logic [CNT_W-1:0]   instret;

    modport master (
        input  OP, Funct, Zero, mem_rdy,
        output mem_req, PCWr, IRWr, RFWr, DMWr, BSel, WDSel, GPRSel,
               NPCOp, EXTOp, ALUOp, state, illegal, instret
    );

    modport slave (
        output OP, Funct, Zero, mem_rdy,
        input  mem_req, PCWr, IRWr, RFWr, DMWr, BSel, WDSel, GPRSel,
               NPCOp, EXTOp, ALUOp, state, illegal, instret
    );
endinterface

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl : multi-cycle MIPS control unit. Sequences every instruction through
// IF -> ID -> EX -> MEM -> WB and drives the datapath strobes/selects from the
// current state plus the IR-held OP/Funct (Mealy on Zero and mem_rdy).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mc_ctrl_if.master (IR fields, ALU flag, memory handshake, strobes,
//        selects, state, illegal flag, retired-instruction counter)
// Parameters: ALUOP_W (ALUOp width, >= 3), MEM_HS (1 = honour mem_rdy,
//             0 = single-cycle memory), CNT_W (instret width).
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- illegal instructions trap to
//   the EXC state and set the sticky illegal flag; otherwise they retire as NOPs.
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int ALUOP_W = 4,
    parameter int MEM_HS  = 1,
    parameter int CNT_W   = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_EXC = 3'd5
    } state_e;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_AND = 6'b100100,
                           FN_OR = 6'b100101, FN_NOR = 6'b100111, FN_SLT = 6'b101010,
                           FN_SRL = 6'b000010, FN_JR = 6'b001000;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                           ALU_NOR = 3'd4, ALU_SLT = 3'd5, ALU_SRL = 3'd6, ALU_PASSB = 3'd7;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       legal_s, is_r_s, is_j_s, is_jal_s, is_jr_s, is_br_s, is_bne_s, is_lw_s, is_sw_s;
    logic       ex_bsel_s;
    logic [1:0] ex_ext_s;
    logic [2:0] ex_alu_s;
    logic       rdy_s;

    logic       mem_req_s, pc_wr_s, ir_wr_s, rf_wr_s, dm_wr_s, bsel_s;
    logic [1:0] wdsel_s, gprsel_s, npcop_s, extop_s;
    logic [2:0] aluop_s;

    // With the handshake disabled every access completes in its first cycle.
    assign rdy_s = (MEM_HS != 0) ? bus.mem_rdy : 1'b1;

    // Instruction decode: class flags plus the EX-stage selects, which MEM/WB
    // reuse since OP/Funct stay stable from ID until the next fetch.
    always_comb begin
        legal_s   = 1'b1;
        is_r_s    = 1'b0;
        is_j_s    = 1'b0;
        is_jal_s  = 1'b0;
        is_jr_s   = 1'b0;
        is_br_s   = 1'b0;
        is_bne_s  = 1'b0;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        ex_bsel_s = 1'b1;
        ex_ext_s  = 2'd0;
        ex_alu_s  = ALU_ADD;
        case (bus.OP)
            OP_R: begin
                is_r_s    = 1'b1;
                ex_bsel_s = 1'b0;
                case (bus.Funct)
                    FN_ADDU: ex_alu_s = ALU_ADD;
                    FN_SUBU: ex_alu_s = ALU_SUB;
                    FN_AND:  ex_alu_s = ALU_AND;
                    FN_OR:   ex_alu_s = ALU_OR;
                    FN_NOR:  ex_alu_s = ALU_NOR;
                    FN_SLT:  ex_alu_s = ALU_SLT;
                    FN_SRL:  ex_alu_s = ALU_SRL;
                    FN_JR:   is_jr_s  = 1'b1;
                    default: legal_s  = 1'b0;
                endcase
            end
            OP_J:    is_j_s = 1'b1;
            OP_JAL:  is_jal_s = 1'b1;
            OP_BEQ:  begin is_br_s = 1'b1; ex_bsel_s = 1'b0; ex_ext_s = 2'd1; ex_alu_s = ALU_SUB; end
            OP_BNE:  begin is_br_s = 1'b1; is_bne_s = 1'b1; ex_bsel_s = 1'b0; ex_ext_s = 2'd1; ex_alu_s = ALU_SUB; end
            OP_ADDI: begin ex_ext_s = 2'd1; ex_alu_s = ALU_ADD; end
            OP_SLTI: begin ex_ext_s = 2'd1; ex_alu_s = ALU_SLT; end
            OP_ANDI: begin ex_ext_s = 2'd0; ex_alu_s = ALU_AND; end
            OP_ORI:  begin ex_ext_s = 2'd0; ex_alu_s = ALU_OR; end
            OP_LUI:  begin ex_ext_s = 2'd2; ex_alu_s = ALU_PASSB; end
            OP_LW:   begin is_lw_s = 1'b1; ex_ext_s = 2'd1; ex_alu_s = ALU_ADD; end
            OP_SW:   begin is_sw_s = 1'b1; ex_ext_s = 2'd1; ex_alu_s = ALU_ADD; end
            default: legal_s = 1'b0;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // Next-state, per-state strobes/selects and retire counting.
    always_comb begin
        state_d   = state_q;
        mem_req_s = 1'b0;
        pc_wr_s   = 1'b0;
        ir_wr_s   = 1'b0;
        rf_wr_s   = 1'b0;
        dm_wr_s   = 1'b0;
        bsel_s    = 1'b0;
        wdsel_s   = 2'd0;
        gprsel_s  = 2'd0;
        npcop_s   = 2'd0;
        extop_s   = 2'd0;
        aluop_s   = ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IF: begin
                mem_req_s = 1'b1;
                if (rdy_s) begin
                    ir_wr_s = 1'b1;
                    pc_wr_s = 1'b1;
                    state_d = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                if (!legal_s) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d   = S_EXC;
                    illegal_d = 1'b1;
`else
                    state_d   = S_IF;
`endif
                end else if (is_j_s || is_jal_s) begin
                    pc_wr_s = 1'b1;
                    npcop_s = 2'd2;
                    if (is_jal_s) begin
                        rf_wr_s  = 1'b1;
                        gprsel_s = 2'd2;
                        wdsel_s  = 2'd2;
                    end else begin
                        rf_wr_s  = 1'b0;
                    end
                    state_d = S_IF;
                end else if (is_jr_s) begin
                    pc_wr_s = 1'b1;
                    npcop_s = 2'd3;
                    state_d = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                bsel_s  = ex_bsel_s;
                extop_s = ex_ext_s;
                aluop_s = ex_alu_s;
                if (is_br_s) begin
                    npcop_s = 2'd1;
                    // BNE takes the branch on !Zero, BEQ on Zero.
                    pc_wr_s = bus.Zero ^ is_bne_s;
                    state_d = S_IF;
                end else if (is_lw_s || is_sw_s) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                bsel_s    = ex_bsel_s;
                extop_s   = ex_ext_s;
                aluop_s   = ex_alu_s;
                dm_wr_s   = is_sw_s;
                if (rdy_s) begin
                    state_d = is_lw_s ? S_WB : S_IF;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                bsel_s   = ex_bsel_s;
                extop_s  = ex_ext_s;
                aluop_s  = ex_alu_s;
                rf_wr_s  = 1'b1;
                wdsel_s  = is_lw_s ? 2'd1 : 2'd0;
                gprsel_s = is_r_s ? 2'd1 : 2'd0;
                state_d  = S_IF;
            end
            S_EXC:   state_d = S_EXC;
            default: state_d = S_IF;
        endcase
        // Every return to fetch from another state retires one instruction.
        if ((state_d == S_IF) && (state_q != S_IF)) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // State and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            instret_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    // Strobes and the memory request are suppressed while reset is asserted so
    // an aborted instruction cannot write anything.
    assign bus.mem_req = mem_req_s & ~rst;
    assign bus.PCWr    = pc_wr_s & ~rst;
    assign bus.IRWr    = ir_wr_s & ~rst;
    assign bus.RFWr    = rf_wr_s & ~rst;
    assign bus.DMWr    = dm_wr_s & ~rst;
    assign bus.BSel    = bsel_s;
    assign bus.WDSel   = wdsel_s;
    assign bus.GPRSel  = gprsel_s;
    assign bus.NPCOp   = npcop_s;
    assign bus.EXTOp   = extop_s;
    assign bus.ALUOp   = ALUOP_W'(aluop_s);
    assign bus.state   = state_q;
    assign bus.instret = instret_q;
endmodule
